alu_instr_fsm: RTL and testbench
================================

# alu_instr_fsm

Multi-cycle controller that sequences the 16-bit ALU datapath (register file, A/B/C pipeline registers, 3-bit status register) for the move and ALU instruction classes. It captures an instruction on a start strobe, decodes it, and steps through read-operand, execute and write-back states. Each state drives the datapath load enables, the register-file addresses, `ALUop` and the source selects. It sits between the instruction register and the datapath and owns all datapath control signals.

## Interface
Parameters:
- none; widths are fixed by the ISA: 16-bit instruction, 3-bit register index, 2-bit `ALUop`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `s`  in  1  start strobe; sampled only in WAIT.
- `in`  in  16  instruction word; captured when `s` is accepted.
- `w`  out  1  1 = idle, ready for `s`.
- `err`  out  1  sticky illegal-instruction flag.
- `readnum`  out  3  register-file read address.
- `writenum`  out  3  register-file write address.
- `write`  out  1  register-file write enable.
- `vsel`  out  1  write-back source: 0 = C register, 1 = `sximm8`.
- `sximm8`  out  16  sign-extended `instr[7:0]` of the latched instruction.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  load enables for A, B, C and the status register.
- `asel`  out  1  1 = ALU A operand forced to 16'h0000.
- `ALUop`  out  2  00 add, 01 sub, 10 and, 11 not B.

## Operation
- **Latched instruction.** `instr` is a 16-bit register, written only on the WAIT&`s` edge. The decode fields are:
  - opcode = `instr[15:13]`
  - op = `instr[12:11]`
  - Rn = `instr[10:8]`
  - Rd = `instr[7:5]`
  - Rm = `instr[2:0]`
- **Supported instructions:**
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm
  - 101/00 ADD Rd,Rn,Rm
  - 101/01 CMP Rn,Rm
  - 101/10 AND Rd,Rn,Rm
  - 101/11 MVN Rd,Rm
  - Anything else, including 110/01 and 110/11, is illegal.
  - `instr[4:3]` (shift) is ignored.
- **States:** WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM. The FSM is Moore; outputs are decoded from the state and `instr` only.
- **Outputs per state.** Outputs not listed are 0. `readnum` and `writenum` are 0 unless listed. `ALUop` is op in EXEC and 00 elsewhere.
  - WAIT: `w`=1. If `s`=1, latch `in`, clear `err`, go to DECODE; otherwise hold.
  - DECODE: no outputs.
    - MOV imm goes to WRITE_IMM.
    - ADD, CMP and AND go to GET_A.
    - MOV reg and MVN go to GET_B.
    - Illegal sets `err`=1 and goes to WAIT.
  - GET_A: `readnum`=Rn, `loada`=1; go to GET_B.
  - GET_B: `readnum`=Rm, `loadb`=1; go to EXEC.
  - EXEC: `ALUop`=op; for MOV reg, `ALUop`=00 and `asel`=1.
    - CMP: `loads`=1, `loadc`=0; go to WAIT.
    - All others: `loadc`=1, `loads`=0; go to WRITE_REG.
  - WRITE_REG: `write`=1, `writenum`=Rd, `vsel`=0; go to WAIT.
  - WRITE_IMM: `write`=1, `writenum`=Rn, `vsel`=1; go to WAIT.
- **Status register.** CMP is the only instruction that loads it.
- **`sximm8`.** Equals {{8{`instr[7]`}},`instr[7:0]`}, combinational from `instr`.

## Timing
- Let edge 0 be the edge where `s` is accepted in WAIT. The states then are:
  - DECODE in cycle 1
  - GET_A in cycle 2 (3-operand instructions)
  - GET_B in cycle 3
  - EXEC in cycle 4
  - WRITE_REG in cycle 5
  - `w`=1 again in cycle 6
- **Latency from `s` to `w`:** 6 cycles for ADD/AND; 5 for CMP, MOV reg and MVN; 3 for MOV imm; 2 for illegal.
- **`s` while busy:** ignored and not queued. `in` changes while busy have no effect.
- **Back-to-back operation:** `s` held high through WAIT starts the next instruction in the same cycle `w` is 1, so there is no dead cycle.
- **Reset:** `reset`=1 at an edge sets state WAIT, `instr`=0 and `err`=0, and takes priority over `s`.
  - Reset outputs: `w`=1; all load enables, `write`, `vsel`, `asel`, `readnum`, `writenum`, `ALUop`=0; `sximm8`=0.
  - Reset mid-operation aborts with no further enables. A reset asserted in the cycle before WRITE_REG prevents that write.

## Test plan
- **Reset:** assert `reset` 1 cycle from an arbitrary state, including EXEC of an ADD. Required: next cycle `w`=1, `err`=0, all enables 0; no `write` pulse follows.
- **MOV imm:** `in`=16'hD2F6 (MOV R2,#-10) with `s`=1. Required: cycle 1 DECODE, no enables; cycle 2 `write`=1, `writenum`=2, `vsel`=1, `sximm8`=16'hFFF6; cycle 3 `w`=1.
- **ADD:** `in`=16'hA168 (ADD R3,R1,R0).
  - Cycle 2: `loada`, `readnum`=1.
  - Cycle 3: `loadb`, `readnum`=0.
  - Cycle 4: `loadc`, `ALUop`=00, `loads`=0.
  - Cycle 5: `write`, `writenum`=3, `vsel`=0.
  - Each enable is exactly 1 cycle wide.
- **CMP and MVN:**
  - CMP `in`=16'hA901: EXEC gives `loads`=1, `ALUop`=01, `loadc`=0, never `write`; `w`=1 at cycle 5.
  - MVN `in`=16'hB8E5: no GET_A; EXEC gives `ALUop`=11; `writenum`=7.
- **MOV reg:** `in`=16'hC0A4. Required: EXEC gives `asel`=1, `ALUop`=00, `loadc`=1; WRITE_REG gives `writenum`=5.
- **Illegal and busy handling:**
  - `in`=16'h1234: `err`=1 from cycle 2, `w`=1 at cycle 2, no enables ever asserted.
  - A following legal start clears `err`.
  - `s` pulsed during a busy ADD is ignored.
  - `s` held high starts back-to-back ADDs with no idle gap.

Source files
------------

// File: rtl/alu_instr_fsm.sv
// alu_instr_fsm: multi-cycle Moore controller for the 16-bit ALU datapath.
// It latches an instruction on a start strobe, decodes it, then walks through
// read-operand, execute and write-back states while driving every datapath
// control: load enables, register-file addresses, ALUop and source selects.
module alu_instr_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic [15:0] sximm8,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic [1:0]  ALUop
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic        err_q, err_d;

    // Decode fields of the latched instruction
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    assign opcode = instr_q[15:13];
    assign op     = instr_q[12:11];
    assign rn     = instr_q[10:8];
    assign rd     = instr_q[7:5];
    assign rm     = instr_q[2:0];

    // Instruction classes; bits [4:3] (shift) play no part
    logic is_alu, is_movi, is_movr, is_cmp, is_mvn;
    assign is_alu  = (opcode == 3'b101);
    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);

    assign sximm8 = {{8{instr_q[7]}}, instr_q[7:0]};
    assign err    = err_q;

    // State, instruction and sticky error registers; reset wins over s
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            instr_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // Next-state and Moore outputs, decoded from state and latched instruction
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        err_d    = err_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        ALUop    = 2'b00;
        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    instr_d = in;
                    err_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_movi)
                    state_d = S_WRITE_IMM;
                else if (is_alu && !is_mvn)
                    state_d = S_GET_A;   // ADD, CMP, AND need Rn
                else if (is_movr || is_mvn)
                    state_d = S_GET_B;   // single-operand forms skip A
                else begin
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_movr) begin
                    // 0 + B passes Rm through the adder unchanged
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else begin
                    ALUop = op;
                end
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                writenum = rd;
                state_d  = S_WAIT;
            end
            S_WRITE_IMM: begin
                write    = 1'b1;
                writenum = rn;
                vsel     = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_fsm.sv
// tb_alu_instr_fsm: cycle-by-cycle comparison of every output against a
// reference model that expands each accepted instruction into its list of
// per-cycle output bundles and replays that list.
module tb_alu_instr_fsm;

    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] in_r;
    logic        w, err, write, vsel, loada, loadb, loadc, loads, asel;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm8;
    logic [1:0]  ALUop;

    alu_instr_fsm dut (
        .clk(clk), .reset(reset), .s(s), .in(in_r),
        .w(w), .err(err), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .sximm8(sximm8),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .ALUop(ALUop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    logic [32:0] exp_q[$];
    logic [15:0] instr_m = 16'h0;
    bit          err_m   = 1'b0;
    bit          armed   = 1'b0;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Bundle order: w err readnum writenum write vsel sximm8 la lb lc ls asel ALUop
    function automatic logic [32:0] mk(bit w_, bit e_, logic [2:0] rn_, logic [2:0] wn_,
                                       bit wr_, bit vs_, bit la_, bit lb_, bit lc_,
                                       bit ls_, bit as_, logic [1:0] op_);
        logic [15:0] sx;
        sx = {{8{instr_m[7]}}, instr_m[7:0]};
        return {w_, e_, rn_, wn_, wr_, vs_, sx, la_, lb_, lc_, ls_, as_, op_};
    endfunction

    function automatic logic [32:0] dut_vec();
        return {w, err, readnum, writenum, write, vsel, sximm8,
                loada, loadb, loadc, loads, asel, ALUop};
    endfunction

    // Expand an accepted instruction into its per-cycle expected outputs
    task automatic accept(input logic [15:0] ins);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op;
        bit movi, movr, add_and, cmp, mvn;
        instr_m = ins;
        err_m   = 1'b0;
        opc = ins[15:13]; op = ins[12:11];
        rn = ins[10:8]; rd = ins[7:5]; rm = ins[2:0];
        movi    = (opc == 3'd6) && (op == 2'd2);
        movr    = (opc == 3'd6) && (op == 2'd0);
        add_and = (opc == 3'd5) && (op == 2'd0 || op == 2'd2);
        cmp     = (opc == 3'd5) && (op == 2'd1);
        mvn     = (opc == 3'd5) && (op == 2'd3);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));            // decode
        if (movi) begin
            exp_q.push_back(mk(0, 0, 0, rn, 1, 1, 0, 0, 0, 0, 0, 0));
        end else if (add_and || cmp || movr || mvn) begin
            if (add_and || cmp)
                exp_q.push_back(mk(0, 0, rn, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, rm, 0, 0, 0, 0, 1, 0, 0, 0, 0));
            if (cmp)
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, op));
            else begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, movr, movr ? 2'd0 : op));
                exp_q.push_back(mk(0, 0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 0));
            end
        end else begin
            err_m = 1'b1;  // becomes visible once the decode cycle drains
        end
    endtask

    // One clock: check outputs at negedge, drive inputs, advance model at posedge
    task automatic cycle(input bit r, input bit st, input logic [15:0] ins);
        @(negedge clk);
        if (armed)
            chk("outputs", dut_vec(),
                (exp_q.size() > 0) ? exp_q[0] : mk(1, err_m, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = r; s = st; in_r = ins;
        @(posedge clk);
        cyc++;
        if (r) begin
            exp_q.delete();
            instr_m = 16'h0;
            err_m   = 1'b0;
            armed   = 1'b1;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (st) begin
            accept(ins);
        end
    endtask

    function automatic logic [15:0] rnd_instr();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0, 1: v[15:13] = 3'b101;
            2:    v[15:13] = 3'b110;
            default: ;
        endcase
        return v;
    endfunction

    logic [15:0] dir_list[7] = '{16'hD2F6, 16'hA168, 16'hA901, 16'hB8E5,
                                 16'hC0A4, 16'h1234, 16'hA168};

    initial begin
        reset = 1'b1; s = 1'b0; in_r = 16'h0;
        cycle(1, 0, 16'h0);
        cycle(1, 1, 16'hA168);   // reset beats s
        cycle(0, 0, 16'h0);

        // Directed: each test-plan instruction, single pulse, then idle
        foreach (dir_list[i]) begin
            cycle(0, 1, dir_list[i]);
            for (int k = 0; k < 7; k++) cycle(0, 0, 16'($urandom));
        end

        // s pulsed while an ADD is busy, plus in changes, must be ignored
        cycle(0, 1, 16'hA168);
        cycle(0, 1, 16'h1234);
        cycle(0, 1, 16'hD2F6);
        for (int k = 0; k < 6; k++) cycle(0, 0, 16'h0);

        // Back-to-back ADDs with s held high
        for (int k = 0; k < 14; k++) cycle(0, 1, 16'hA168);
        cycle(0, 0, 16'h0);

        // Reset in EXEC of an ADD: no write may follow
        cycle(0, 1, 16'hA168);
        for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0);
        cycle(1, 0, 16'h0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 16'h0);

        // Illegal then reset clears err; illegal then legal clears err
        cycle(0, 1, 16'hE000);
        for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0);
        cycle(1, 0, 16'h0);
        cycle(0, 1, 16'hC800);
        for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0);
        cycle(0, 1, 16'hC0A4);
        for (int k = 0; k < 6; k++) cycle(0, 0, 16'h0);

        // Random phase
        for (int k = 0; k < 4000; k++)
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 2) != 0, rnd_instr());
        cycle(0, 0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
